// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, default
// frame parameters and a counter-width helper.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEF_BIT_TICKS = 16;
  localparam int DEF_DATA_BITS = 8;

  // Counters never collapse to zero width, even for a range of 1 or 2.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with a registered occupancy count and a
// combinational head-of-queue read port.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // A full FIFO refuses writes even when a read frees a slot this cycle.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1-style serial transmitter: buffers bytes in a FIFO and shifts each out
// MSB first as start bit, data bits and stop bit(s), BIT_TICKS clocks per bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BIT_TICKS  = DEF_BIT_TICKS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int TW = cnt_w(BIT_TICKS);
  localparam int BW = cnt_w(DATA_BITS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  tx_state_t            state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 tick_end;
  logic                 pop;

  assign tick_end = (tick == TICK_LAST);
  // Popping on the last stop tick chains frames with no idle gap.
  assign pop      = !empty && ((state == IDLE) ||
                    (state == STOP && tick_end && stop_cnt == STOP_LAST));
  assign in_ready = !full;
  assign busy     = (state != IDLE) || (count != '0);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= head;
            tick  <= '0;
            state <= START;
          end
        end
        START: begin
          tx   <= 1'b0;
          tick <= tick_end ? '0 : tick + 1'b1;
          if (tick_end) begin
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          tx   <= shift[DATA_BITS-1];
          tick <= tick_end ? '0 : tick + 1'b1;
          if (tick_end) begin
            shift <= shift << 1;
            if (bit_cnt == BIT_LAST) begin
              stop_cnt <= 1'b0;
              state    <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          tx   <= 1'b1;
          tick <= tick_end ? '0 : tick + 1'b1;
          if (tick_end) begin
            if (stop_cnt == STOP_LAST) begin
              if (pop) begin
                shift <= head;
                state <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: scoreboarded bytes decoded from the serial line of a
// default instance and a 2-stop-bit, 4-tick instance.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data_a, in_data_b;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] exp_qa[$];
  logic [7:0] exp_qb[$];
  int         starts_a[$];
  int         starts_b[$];
  bit         abort_a = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.BIT_TICKS(16), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .tx(tx_a), .busy(busy_a));

  uart_tx #(.BIT_TICKS(4), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: low start bit, 8 data bits MSB first, sb high stop bits.
  function automatic logic [8:0] decode(input logic s [0:199], input int bt, input int sb);
    logic [7:0] d;
    logic       ok;
    logic       e;
    int         r;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) d[7-k] = s[(k + 1) * bt];
    for (int c = 0; c < (9 + sb) * bt; c++) begin
      r = c / bt;
      if (r == 0) e = 1'b0;
      else if (r <= 8) e = d[8-r];
      else e = 1'b1;
      if (s[c] !== e) ok = 1'b0;
    end
    return {ok, d};
  endfunction

  initial begin : mon_a
    logic       s [0:199];
    logic [8:0] r;
    bit         ab;
    forever begin
      @(negedge clk);
      if (abort_a) abort_a = 1'b0;
      else if (tx_a === 1'b0) begin
        starts_a.push_back(cyc);
        ab = 1'b0;
        for (int i = 0; i < 160; i++) begin
          if (i > 0) begin
            @(negedge clk);
            if (abort_a) begin
              abort_a = 1'b0;
              ab = 1'b1;
              break;
            end
          end
          s[i] = tx_a;
        end
        if (!ab) begin
          r = decode(s, 16, 1);
          check("a_frame_expected", int'(exp_qa.size() != 0), 1);
          check("a_frame_shape", r[8], 1);
          if (exp_qa.size() != 0) check("a_frame_byte", r[7:0], exp_qa.pop_front());
        end
      end
    end
  end

  initial begin : mon_b
    logic       s [0:199];
    logic [8:0] r;
    forever begin
      @(negedge clk);
      if (tx_b === 1'b0) begin
        starts_b.push_back(cyc);
        for (int i = 0; i < 44; i++) begin
          if (i > 0) @(negedge clk);
          s[i] = tx_b;
        end
        r = decode(s, 4, 2);
        check("b_frame_expected", int'(exp_qb.size() != 0), 1);
        check("b_frame_shape", r[8], 1);
        if (exp_qb.size() != 0) check("b_frame_byte", r[7:0], exp_qb.pop_front());
      end
    end
  end

  // Presents a byte; acc is the clock edge number on which it is accepted.
  task automatic push_a(input logic [7:0] b, input int budget, output int acc);
    int n = 0;
    @(negedge clk);
    in_valid_a = 1'b1;
    in_data_a  = b;
    while (in_ready_a !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (in_ready_a === 1'b1) begin
      exp_qa.push_back(b);
      acc = cyc + 1;
    end else begin
      check("a_push_timeout", n, 0);
      acc = -1;
    end
    @(posedge clk);
    #1 in_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] b, input int budget, output int acc);
    int n = 0;
    @(negedge clk);
    in_valid_b = 1'b1;
    in_data_b  = b;
    while (in_ready_b !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (in_ready_b === 1'b1) begin
      exp_qb.push_back(b);
      acc = cyc + 1;
    end else begin
      check("b_push_timeout", n, 0);
      acc = -1;
    end
    @(posedge clk);
    #1 in_valid_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy_a !== 1'b0 || exp_qa.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("a_drain_in_budget", int'(n < budget), 1);
  endtask

  task automatic wait_idle_b(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy_b !== 1'b0 || exp_qb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("b_drain_in_budget", int'(n < budget), 1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int acc, acc0, acc6, accb, accb2, base, s, n, got;
    rst = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0;
    in_valid_b = 1'b0; in_data_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("a_reset_tx", tx_a, 1);
    check("a_reset_busy", busy_a, 0);
    check("a_reset_ready", in_ready_a, 1);
    check("b_reset_tx", tx_b, 1);

    // Single byte: latency, then busy around the end of the frame.
    base = starts_a.size();
    push_a(8'hA5, 10, acc);
    n = 0;
    while (starts_a.size() <= base && n < 50) begin @(negedge clk); n++; end
    check("a_single_started", starts_a.size() - base, 1);
    if (starts_a.size() > base) check("a_start_latency", starts_a[base] - acc, 2);
    wait_cyc(acc + 159);
    check("a_busy_in_stop", busy_a, 1);
    wait_cyc(acc + 162);
    check("a_busy_after_frame", busy_a, 0);
    wait_idle_a(400);

    // Burst: FIFO fills, sixth byte waits for the first pop, frames contiguous.
    base = starts_a.size();
    push_a(8'h00, 10, acc0);
    push_a(8'hFF, 10, acc);
    push_a(8'h55, 10, acc);
    push_a(8'h81, 10, acc);
    push_a(8'h42, 10, acc);
    check("a_burst_fifth_edge", acc - acc0, 4);
    @(negedge clk);
    check("a_full_not_ready", in_ready_a, 0);
    push_a(8'h99, 400, acc6);
    check("a_refill_edge", acc6 - acc0, 162);
    wait_idle_a(2000);
    check("a_burst_frames", starts_a.size() - base, 6);
    for (int k = 1; k < 6; k++)
      if (base + k < starts_a.size())
        check("a_burst_gap", starts_a[base+k] - starts_a[base+k-1], 160);

    // Reset during data bit 3 with two bytes queued, push offered under reset.
    base = starts_a.size();
    push_a(8'hC3, 10, acc);
    push_a(8'h11, 10, acc);
    push_a(8'h22, 10, acc);
    n = 0;
    while (starts_a.size() <= base && n < 50) begin @(negedge clk); n++; end
    s = (starts_a.size() > base) ? starts_a[base] : cyc;
    wait_cyc(s + 70);
    rst = 1'b1;
    abort_a = 1'b1;
    exp_qa.delete();
    in_valid_a = 1'b1;
    in_data_a  = 8'hEE;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid_a = 1'b0;
    @(negedge clk);
    check("a_rst_tx_high", tx_a, 1);
    check("a_rst_busy_low", busy_a, 0);
    check("a_rst_ready", in_ready_a, 1);
    repeat (400) @(negedge clk);
    check("a_rst_no_frames", starts_a.size() - base, 1);
    check("a_rst_still_idle", busy_a, 0);
    push_a(8'h3C, 10, acc);
    wait_idle_a(400);
    check("a_post_rst_frames", starts_a.size() - base, 2);

    // Random traffic with in_valid toggling, including while the FIFO is full.
    base = starts_a.size();
    got = 0;
    n = 0;
    while (got < 64 && n < 20000) begin
      @(negedge clk);
      in_valid_a = ($urandom_range(0, 3) != 0);
      in_data_a  = 8'($urandom);
      if (in_valid_a && in_ready_a === 1'b1) begin
        exp_qa.push_back(in_data_a);
        got++;
      end
      n++;
    end
    @(negedge clk);
    in_valid_a = 1'b0;
    check("a_random_accepted", got, 64);
    wait_idle_a(3000);
    check("a_random_frames", starts_a.size() - base, 64);

    // Two stop bits, four ticks per bit.
    base = starts_b.size();
    push_b(8'hF0, 10, accb);
    push_b(8'h0F, 10, accb2);
    wait_idle_b(300);
    check("b_frames", starts_b.size() - base, 2);
    if (starts_b.size() > base) check("b_start_latency", starts_b[base] - accb, 2);
    if (starts_b.size() > base + 1) check("b_frame_gap", starts_b[base+1] - starts_b[base], 44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
